// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end.
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the byte PC it came from.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    // Instruction PCs are always word aligned; the low two bits are dropped.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] p);
        return p & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched instructions between the I-memory and decode.
// Head, count and valid all come straight from flops.
module fetch_queue
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          valid,
    output fetch_entry_t  head
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    fetch_entry_t  entry_vec [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Pointer and occupancy update; a flush overrides any push/pop this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        valid_d = (count_d != '0);
    end

    // Pointer, count and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_q, entry_d;

            // Capture the pushed word when this slot is the write target.
            always_comb begin
                entry_d = entry_q;
                if (push && !flush && (wr_ptr_q == PW'(gi))) begin
                    entry_d = push_data;
                end
            end

            // Storage slot; cleared on reset so the head reads as a NOP at pc 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '{instr: INSTR_NOP, pc: '0};
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entry_vec[gi] = entry_q;
        end
    endgenerate

    assign head  = entry_vec[rd_ptr_q];
    assign count = count_q;
    assign valid = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues synchronous I-memory reads on a
// credit basis so the prefetch queue can never overflow, and restarts fetch on
// datapath redirects.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 8,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;

    logic [CW-1:0] q_count;
    logic          q_valid;
    fetch_entry_t  q_head;
    fetch_entry_t  push_entry;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit_used;

    // Handshake, credit check and return handling. Entries still owed to the
    // queue (in-flight read) count against its capacity; an entry leaving this
    // cycle frees a slot. Holding reset suppresses the read strobe.
    always_comb begin
        pop         = q_valid && instr_ready;
        credit_used = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue       = rst_n && !redirect_valid && (credit_used < (CW+1)'(QDEPTH));
        push        = inflight_q && !redirect_valid;
        push_entry  = '{instr: imem_rdata, pc: inflight_pc_q};
    end

    // PC and in-flight tracking; a redirect wins over sequential fetch.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .valid     (q_valid),
        .head      (q_head)
    );

    assign imem_en     = issue;
    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign instr_valid = q_valid;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: synchronous memory model plus a queue-based
// reference of the fetch stream, checked every cycle.
module tb_instr_fetch_stage;
    import mips_pkg::*;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [256];

    // Reference state
    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    logic         m_inf;
    logic [31:0]  m_inf_pc;
    int           cyc_n;
    int           first_valid;

    instr_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (8),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc        = 32'h0000_0000;
        m_inf       = 1'b0;
        m_inf_pc    = '0;
        cyc_n       = 0;
        first_valid = -1;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rst_n          = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check against the reference, advance it.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic exp_valid, pop, iss;
        int   used;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        pop       = exp_valid && rdy;
        used      = mq.size() - int'(pop) + int'(m_inf);
        iss       = !rv && (used < QD);
        chk("imem_en", 32'(imem_en), 32'(iss));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc[9:2]));
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("instr", instr, mq[0].instr);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        if (instr_valid === 1'b1 && first_valid < 0) first_valid = cyc_n;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
        end else if (m_inf) begin
            mq.push_back('{instr: mem[m_inf_pc[9:2]], pc: m_inf_pc});
        end
        if (rv)       m_pc = {rpc[31:2], 2'b00};
        else if (iss) m_pc = m_pc + 32'd4;
        if (iss) m_inf_pc = m_pc - 32'd4;
        m_inf = iss;
        cyc_n++;
    endtask

    initial begin
        logic [31:0] rpc;
        for (int k = 0; k < 256; k++) mem[k] = 32'h2000_0000 + k;
        model_reset();
        #1;

        // Streaming from reset: first valid in cycle 2, then pcs 0,4,8,12...
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        chk("first_valid_cycle", 32'(first_valid), 32'd2);

        // Backpressure from cycle 2 for 5 cycles, then release.
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Redirect to 0x43 in cycle 6 with the queue full.
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0043);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Redirect coinciding with a pop and an in-flight return.
        step(1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0);

        // Randomized traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                for (int j = 0; j < 3; j++) step(1'b1, 1'b0, '0);
                do_reset();
                for (int j = 0; j < 4; j++) step(1'b1, 1'b0, '0);
                chk("first_valid_after_rst", 32'(first_valid), 32'd2);
            end
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
